// File: rtl/dropoff_pkg.sv
// Shared types and default constants for the dropoff limit scheduler and its
// single-station evaluator.
package dropoff_pkg;

    localparam int DATA_W                  = 32;
    localparam int DEF_MAX_STOREABLE       = 128000;
    localparam int DEF_UNITS_IN_TRAIN_LOAD = 8000;
    localparam int DEF_QUEUE_LENGTH        = 3;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_LIMIT   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

endpackage

// File: rtl/dropoff_station_eval.sv
// Combinational evaluation of one dropoff station: adjusted stock, stored
// percentage and train limit against the group average.
module dropoff_station_eval
    import dropoff_pkg::*;
#(
    parameter int INT                 = 31,
    parameter int QUEUE_LENGTH        = DEF_QUEUE_LENGTH,
    parameter int MAX_STOREABLE       = DEF_MAX_STOREABLE,
    parameter int UNITS_IN_TRAIN_LOAD = DEF_UNITS_IN_TRAIN_LOAD
) (
    input  logic [INT:0] units,
    input  logic [INT:0] train_count,
    input  logic [INT:0] stopped_train_id,
    input  logic [INT:0] precision,
    input  logic [INT:0] avg,
    input  logic         enable,
    output logic [INT:0] adjusted,
    output logic [INT:0] scaled,
    output logic [INT:0] scaled_actual,
    output logic [INT:0] limit
);
    localparam int DW = INT + 1;
    localparam int WW = 2 * DW;
    localparam logic [WW-1:0] M_W   = WW'(MAX_STOREABLE);
    localparam logic [WW-1:0] W_W   = WW'(UNITS_IN_TRAIN_LOAD);
    localparam logic [WW-1:0] Q_W   = WW'(QUEUE_LENGTH);
    localparam logic [WW-1:0] ONE_W = WW'(1);
    localparam logic [DW-1:0] ZERO  = {DW{1'b0}};
    localparam logic [DW-1:0] ONE   = DW'(1);

    logic [WW-1:0] z_s;
    logic [WW-1:0] adj_w_s;
    logic [WW-1:0] prec_w_s;
    logic [WW-1:0] prec_div_s;
    logic [WW-1:0] free_s;
    logic [WW-1:0] deficit_s;
    logic [WW-1:0] lim_s;
    logic [DW-1:0] deficit_units_s;

    // Station arithmetic; the train in the stop slot is not counted as inbound.
    always_comb begin
        z_s             = {WW{1'b0}};
        free_s          = {WW{1'b0}};
        deficit_s       = {WW{1'b0}};
        lim_s           = {WW{1'b0}};
        deficit_units_s = ZERO;
        if (stopped_train_id == ZERO) begin
            z_s = {ZERO, train_count};
        end else if (train_count == ZERO) begin
            z_s = {WW{1'b0}};
        end else begin
            z_s = {ZERO, train_count - ONE};
        end
        adj_w_s       = {ZERO, units} + z_s * W_W;
        prec_w_s      = {ZERO, precision};
        prec_div_s    = (precision == ZERO) ? ONE_W : prec_w_s;
        adjusted      = adj_w_s[DW-1:0];
        scaled        = DW'((adj_w_s * prec_w_s) / M_W);
        scaled_actual = DW'(({ZERO, units} * prec_w_s) / M_W);
        if (adj_w_s >= M_W) begin
            free_s = {WW{1'b0}};
        end else begin
            free_s = (M_W - adj_w_s) / W_W;
        end
        deficit_units_s = DW'(({ZERO, avg - scaled_actual} * M_W) / prec_div_s);
        deficit_s       = {ZERO, deficit_units_s} / W_W;
        if (deficit_s < ONE_W) begin
            deficit_s = ONE_W;
        end else begin
            deficit_s = deficit_s;
        end
        lim_s = Q_W;
        if (free_s < lim_s) begin
            lim_s = free_s;
        end else begin
            lim_s = lim_s;
        end
        if (deficit_s < lim_s) begin
            lim_s = deficit_s;
        end else begin
            lim_s = lim_s;
        end
        if (!enable || (precision == ZERO) || (scaled_actual > avg)) begin
            limit = ZERO;
        end else begin
            limit = lim_s[DW-1:0];
        end
    end

endmodule

// File: rtl/dropoff_limit_scheduler.sv
// Sequential group scheduler: snapshots station inputs, sums stored percentages,
// then derives per-station train limits with one shared evaluator.
module dropoff_limit_scheduler
    import dropoff_pkg::*;
#(
    parameter int NUM_STATIONS        = 4,
    parameter int QUEUE_LENGTH        = DEF_QUEUE_LENGTH,
    parameter int MAX_STOREABLE       = DEF_MAX_STOREABLE,
    parameter int UNITS_IN_TRAIN_LOAD = DEF_UNITS_IN_TRAIN_LOAD,
    parameter int INT                 = 31
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [INT:0]                      precision,
    input  logic [NUM_STATIONS-1:0]           station_enable,
    input  logic [NUM_STATIONS*(INT+1)-1:0]   units_at_station,
    input  logic [NUM_STATIONS*(INT+1)-1:0]   train_count,
    input  logic [NUM_STATIONS*(INT+1)-1:0]   stopped_train_id,
    output logic                              busy,
    output logic                              done,
    output logic [INT:0]                      total_percentage_stored,
    output logic [NUM_STATIONS*(INT+1)-1:0]   trains_limit
);
    localparam int DW    = INT + 1;
    localparam int VW    = NUM_STATIONS * DW;
    localparam int IDX_W = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STATIONS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [DW-1:0]    ZERO     = {DW{1'b0}};

    state_t                  state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [DW-1:0]           acc_r;
    logic [DW-1:0]           snap_prec_r;
    logic [NUM_STATIONS-1:0] snap_en_r;
    logic [VW-1:0]           snap_units_r;
    logic [VW-1:0]           snap_count_r;
    logic [VW-1:0]           snap_tid_r;
    logic [VW-1:0]           shadow_r;

    logic [DW-1:0] cur_units_s;
    logic [DW-1:0] cur_count_s;
    logic [DW-1:0] cur_tid_s;
    logic          cur_en_s;
    logic [DW-1:0] group_s;
    logic [DW-1:0] avg_s;
    logic [DW:0]   acc_sum_s;
    logic [DW-1:0] acc_next_s;
    logic [DW-1:0] adjusted_s;
    logic [DW-1:0] scaled_s;
    logic [DW-1:0] scaled_actual_s;
    logic [DW-1:0] limit_s;

    assign cur_units_s = snap_units_r[idx_r*DW +: DW];
    assign cur_count_s = snap_count_r[idx_r*DW +: DW];
    assign cur_tid_s   = snap_tid_r[idx_r*DW +: DW];
    assign cur_en_s    = snap_en_r[idx_r];

    // Group size, group average and the saturating accumulator update.
    always_comb begin
        group_s = ZERO;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            group_s = group_s + {{INT{1'b0}}, snap_en_r[i]};
        end
        if (group_s == ZERO) begin
            avg_s = ZERO;
        end else begin
            avg_s = acc_r / group_s;
        end
        acc_sum_s = {1'b0, acc_r} + {1'b0, scaled_s};
        if (acc_sum_s[DW]) begin
            acc_next_s = {DW{1'b1}};
        end else begin
            acc_next_s = acc_sum_s[DW-1:0];
        end
    end

    dropoff_station_eval #(
        .INT                 (INT),
        .QUEUE_LENGTH        (QUEUE_LENGTH),
        .MAX_STOREABLE       (MAX_STOREABLE),
        .UNITS_IN_TRAIN_LOAD (UNITS_IN_TRAIN_LOAD)
    ) u_eval (
        .units            (cur_units_s),
        .train_count      (cur_count_s),
        .stopped_train_id (cur_tid_s),
        .precision        (snap_prec_r),
        .avg              (avg_s),
        .enable           (cur_en_s),
        .adjusted         (adjusted_s),
        .scaled           (scaled_s),
        .scaled_actual    (scaled_actual_s),
        .limit            (limit_s)
    );

    // Run sequencer: snapshot, scan pass, limit pass, atomic publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r                 <= ST_IDLE;
            idx_r                   <= '0;
            acc_r                   <= '0;
            snap_prec_r             <= '0;
            snap_en_r               <= '0;
            snap_units_r            <= '0;
            snap_count_r            <= '0;
            snap_tid_r              <= '0;
            shadow_r                <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            total_percentage_stored <= '0;
            trains_limit            <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        snap_prec_r  <= precision;
                        snap_en_r    <= station_enable;
                        snap_units_r <= units_at_station;
                        snap_count_r <= train_count;
                        snap_tid_r   <= stopped_train_id;
                        acc_r        <= '0;
                        idx_r        <= '0;
                        state_r      <= ST_SCAN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (cur_en_s) begin
                        acc_r <= acc_next_s;
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        idx_r   <= '0;
                        state_r <= ST_LIMIT;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_LIMIT: begin
                    shadow_r[idx_r*DW +: DW] <= limit_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r   <= '0;
                        state_r <= ST_PUBLISH;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_PUBLISH: begin
                    trains_limit            <= shadow_r;
                    total_percentage_stored <= acc_r;
                    done                    <= 1'b1;
                    state_r                 <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dropoff_limit_scheduler.sv
// Scoreboard bench for dropoff_limit_scheduler: a driver pushes model results,
// a monitor pops them on done and compares, plus stability and reset checks.
module tb_dropoff_limit_scheduler;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam longint unsigned QL   = 3;
    localparam longint unsigned MS   = 128000;
    localparam longint unsigned WL   = 8000;
    localparam longint unsigned MASK = 64'hFFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [31:0]     precision = '0;
    logic [N-1:0]    station_enable = '0;
    logic [N*DW-1:0] units_at_station = '0;
    logic [N*DW-1:0] train_count = '0;
    logic [N*DW-1:0] stopped_train_id = '0;
    logic            busy;
    logic            done;
    logic [31:0]     total_percentage_stored;
    logic [N*DW-1:0] trains_limit;

    dropoff_limit_scheduler #(.NUM_STATIONS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .precision(precision),
        .station_enable(station_enable), .units_at_station(units_at_station),
        .train_count(train_count), .stopped_train_id(stopped_train_id),
        .busy(busy), .done(done), .total_percentage_stored(total_percentage_stored),
        .trains_limit(trains_limit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     r;
        logic [N*DW-1:0] l;
        int              c0;
    } exp_t;

    exp_t            sb[$];
    int              errs = 0;
    int              chks = 0;
    int              cyc = 0;
    logic [31:0]     last_r = '0;
    logic [N*DW-1:0] last_l = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint unsigned act, input longint unsigned req);
        chks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference: straight from the station rules with 64-bit arithmetic.
    function automatic void model(input logic [N*DW-1:0] u, input logic [N*DW-1:0] c,
                                  input logic [N*DW-1:0] t, input logic [31:0] p,
                                  input logic [N-1:0] en, output logic [31:0] r,
                                  output logic [N*DW-1:0] l);
        longint unsigned a [N];
        longint unsigned acc, g, avg, sa, fr, df, lim, z, uu, cc, tt, pp;
        acc = 0; g = 0; pp = p;
        for (int i = 0; i < N; i++) begin
            uu = u[i*DW +: DW]; cc = c[i*DW +: DW]; tt = t[i*DW +: DW];
            if (tt == 0) z = cc;
            else z = (cc == 0) ? 0 : cc - 1;
            a[i] = uu + z * WL;
            if (en[i]) begin
                g++;
                acc = acc + ((a[i] * pp / MS) & MASK);
                if (acc > MASK) acc = MASK;
            end
        end
        r = acc[31:0];
        avg = (g == 0) ? 0 : acc / g;
        l = '0;
        for (int i = 0; i < N; i++) begin
            uu = u[i*DW +: DW];
            sa = (uu * pp / MS) & MASK;
            if (!en[i] || g == 0 || pp == 0 || sa > avg) begin
                lim = 0;
            end else begin
                fr = (a[i] >= MS) ? 0 : (MS - a[i]) / WL;
                df = (((avg - sa) * MS / pp) & MASK) / WL;
                if (df < 1) df = 1;
                lim = QL;
                if (fr < lim) lim = fr;
                if (df < lim) lim = df;
            end
            l[i*DW +: DW] = lim[31:0];
        end
    endfunction

    // Monitor: score each published result, and check published outputs hold mid-run.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chks++; errs++;
                    $display("FAIL spurious_done: got done=1 expected no pending run");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("total", total_percentage_stored, e.r);
                    for (int i = 0; i < N; i++)
                        check($sformatf("limit%0d", i), trains_limit[i*DW +: DW], e.l[i*DW +: DW]);
                    check("done_latency", cyc - e.c0, 2*N + 1);
                    last_r = e.r;
                    last_l = e.l;
                end
            end else if (busy === 1'b1) begin
                check("hold_total", total_percentage_stored, last_r);
                check("hold_limits", (trains_limit == last_l) ? 1 : 0, 1);
            end
        end
    end

    task automatic set_inputs(input logic [N*DW-1:0] u, input logic [N*DW-1:0] c,
                              input logic [N*DW-1:0] t, input logic [31:0] p, input logic [N-1:0] en);
        units_at_station = u; train_count = c; stopped_train_id = t;
        precision = p; station_enable = en;
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            units_at_station[i*DW +: DW] = $urandom_range(0, 200000);
            train_count[i*DW +: DW]      = $urandom_range(0, 20);
            stopped_train_id[i*DW +: DW] = $urandom_range(0, 3);
        end
        precision = $urandom_range(0, 2000);
        station_enable = N'($urandom);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        if (!seen) begin
            chks++; errs++;
            $display("FAIL timeout: got no done expected done within 40 cycles");
        end
    endtask

    // Issue one run from a negedge; optionally hold start and/or disturb inputs mid-run.
    task automatic run(input logic [N*DW-1:0] u, input logic [N*DW-1:0] c, input logic [N*DW-1:0] t,
                       input logic [31:0] p, input logic [N-1:0] en, input bit hold, input bit disturb);
        exp_t e;
        set_inputs(u, c, t, p, en);
        model(u, c, t, p, en, e.r, e.l);
        start = 1'b1;
        @(posedge clk); #1;
        e.c0 = cyc;
        sb.push_back(e);
        check("busy_after_start", busy, 1);
        if (!hold) start = 1'b0;
        if (disturb) scramble();
        wait_done();
        start = 1'b0;
    endtask

    function automatic logic [N*DW-1:0] rep(input logic [31:0] v);
        logic [N*DW-1:0] x;
        for (int i = 0; i < N; i++) x[i*DW +: DW] = v;
        return x;
    endfunction

    logic [N*DW-1:0] u_v, c_v, t_v;

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_total", total_percentage_stored, 0);
        check("rst_limits", (trains_limit == '0) ? 1 : 0, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Uniform half-full stations.
        run(rep(32'd64000), '0, '0, 32'd1000, 4'b1111, 0, 0);
        // One empty station among full ones.
        u_v = rep(32'd128000); u_v[31:0] = 32'd0;
        run(u_v, '0, '0, 32'd1000, 4'b1111, 0, 0);
        // Single enabled station, then none enabled.
        u_v = rep(32'd0); u_v[31:0] = 32'd32000;
        run(u_v, '0, '0, 32'd1000, 4'b0001, 0, 0);
        run(u_v, '0, '0, 32'd1000, 4'b0000, 0, 0);
        // Inbound train fills station 0; stopped id with zero count on station 1.
        u_v = rep(32'd20000); u_v[31:0] = 32'd128000;
        c_v = '0; c_v[31:0] = 32'd1;
        t_v = '0; t_v[63:32] = 32'd5;
        run(u_v, c_v, t_v, 32'd1000, 4'b1111, 0, 0);
        // start held through a run, then idle.
        run(rep(32'd50000), rep(32'd1), rep(32'd0), 32'd1000, 4'b1111, 1, 0);
        @(negedge clk);
        check("busy_after_hold", busy, 0);
        // Inputs disturbed after the snapshot.
        u_v = rep(32'd10000); u_v[95:64] = 32'd90000;
        run(u_v, rep(32'd2), rep(32'd1), 32'd1000, 4'b1111, 0, 1);
        // Accumulator saturation.
        run(rep(32'd400000000), '0, '0, 32'd1000000, 4'b1111, 0, 0);
        // Zero precision.
        run(rep(32'd30000), '0, '0, 32'd0, 4'b1111, 0, 0);

        // Reset during the limit pass.
        set_inputs(rep(32'd5000), '0, '0, 32'd1000, 4'b1111);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (N + 2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_total", total_percentage_stored, 0);
        check("midrst_limits", (trains_limit == '0) ? 1 : 0, 1);
        sb.delete();
        last_r = '0; last_l = '0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run(rep(32'd5000), '0, '0, 32'd1000, 4'b1111, 0, 0);

        // Randomised runs, some back-to-back with start held.
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) begin
                u_v[i*DW +: DW] = $urandom_range(0, 200000);
                c_v[i*DW +: DW] = $urandom_range(0, 20);
                t_v[i*DW +: DW] = $urandom_range(0, 3);
            end
            run(u_v, c_v, t_v, ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 2000)),
                N'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
